// File: rtl/draw_sequencer.sv
// Unique-value draw sequencer: pulls candidates from an external LFSR, rejects
// out-of-range or repeated values, and hands N_DRAW unique draws to a consumer.
module draw_sequencer #(
  parameter int MAX_VAL = 79,
  parameter int N_DRAW  = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cand,
  input  logic       cand_vld,
  output logic       cand_req,
  output logic [7:0] draw_num,
  output logic       draw_vld,
  input  logic       draw_rdy,
  output logic [6:0] draw_idx,
  output logic       busy,
  output logic       done,
  output logic [7:0] reject_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, CHECK, OUTPUT, DONE} state_t;

  localparam logic [7:0] MAX_V    = 8'(MAX_VAL);
  localparam logic [6:0] LAST_IDX = 7'(N_DRAW - 1);

  state_t       state;
  logic         start_q;
  logic         start_edge;
  logic [7:0]   cand_q;
  logic [127:0] used;
  logic         reject;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign start_edge = start & ~start_q;
  // cand_q[7] set means > 127, which the MAX_V compare already rejects
  assign reject = (cand_q == 8'd0) || (cand_q > MAX_V) || used[cand_q[6:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      cand_q     <= '0;
      used       <= '0;
      cand_req   <= 1'b0;
      draw_num   <= '0;
      draw_vld   <= 1'b0;
      draw_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      reject_cnt <= '0;
    end else begin
      start_q <= start;
      done    <= 1'b0;
      if (abort && state != IDLE) begin
        state    <= IDLE;
        busy     <= 1'b0;
        cand_req <= 1'b0;
        draw_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge && !abort) begin
              state <= CLEAR;
              busy  <= 1'b1;
            end
          end
          CLEAR: begin
            used       <= '0;
            draw_idx   <= '0;
            reject_cnt <= '0;
            state      <= FETCH;
            cand_req   <= 1'b1;
          end
          FETCH: begin
            if (cand_vld) begin
              cand_q   <= cand;
              state    <= CHECK;
              cand_req <= 1'b0;
            end
          end
          CHECK: begin
            if (reject) begin
              reject_cnt <= sat_inc(reject_cnt);
              state      <= FETCH;
              cand_req   <= 1'b1;
            end else begin
              used[cand_q[6:0]] <= 1'b1;
              draw_num          <= cand_q;
              draw_vld          <= 1'b1;
              state             <= OUTPUT;
            end
          end
          OUTPUT: begin
            if (draw_rdy) begin
              draw_vld <= 1'b0;
              if (draw_idx == LAST_IDX) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                draw_idx <= draw_idx + 7'd1;
                state    <= FETCH;
                cand_req <= 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            cand_req <= 1'b0;
            draw_vld <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer with a transaction-level uniqueness model
// and a per-cycle compare process.
module tb_draw_sequencer;
  localparam int MAX_VAL = 79;
  localparam int N_DRAW  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cand = '0;
  logic       cand_vld = 1'b0;
  logic       cand_req;
  logic [7:0] draw_num;
  logic       draw_vld;
  logic       draw_rdy = 1'b0;
  logic [6:0] draw_idx;
  logic       busy;
  logic       done;
  logic [7:0] reject_cnt;

  draw_sequencer #(.MAX_VAL(MAX_VAL), .N_DRAW(N_DRAW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cand(cand), .cand_vld(cand_vld), .cand_req(cand_req),
    .draw_num(draw_num), .draw_vld(draw_vld), .draw_rdy(draw_rdy),
    .draw_idx(draw_idx), .busy(busy), .done(done), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  // Model state: which values this session has already produced
  bit   [255:0] m_seen;
  int           m_rej;
  int           m_idx;
  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_seen = '0;
    m_rej  = 0;
    m_idx  = 0;
    exp_q.delete();
    got_q.delete();
  endfunction

  function automatic void model_cand(input logic [7:0] c);
    if (c != 8'd0 && int'(c) <= MAX_VAL && !m_seen[c]) begin
      m_seen[c] = 1'b1;
      exp_q.push_back(c);
    end else if (m_rej < 255) begin
      m_rej++;
    end
  endfunction

  // Per-cycle compare
  logic       pv = 1'b0, prdy = 1'b0, pd = 1'b0;
  logic [7:0] pnum = '0;
  logic [6:0] pidx = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_with_vld", int'(cand_req & draw_vld), 0);
      chk("done_width", int'(done & pd), 0);
      if (draw_vld && pv && !prdy) begin
        chk("hold_num", draw_num, pnum);
        chk("hold_idx", draw_idx, pidx);
      end
      if (draw_vld && draw_rdy) begin
        if (exp_q.size() == 0) chk("unexpected_draw", draw_num, -1);
        else chk("draw_num", draw_num, exp_q.pop_front());
        chk("draw_idx", draw_idx, m_idx);
        chk("rej_at_draw", reject_cnt, m_rej);
        got_q.push_back(draw_num);
        m_idx++;
      end
      if (done) begin
        done_cnt++;
        chk("done_idx", draw_idx, N_DRAW - 1);
        chk("done_rej", reject_cnt, m_rej);
        chk("done_pending", exp_q.size(), 0);
      end
    end
    pv = draw_vld; prdy = draw_rdy; pd = done; pnum = draw_num; pidx = draw_idx;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_session(input bit hold);
    model_reset();
    start = 1'b1;
    step(1);
    if (!hold) start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] c);
    int n = 0;
    while (!cand_req && n < 50) begin step(1); n++; end
    if (!cand_req) begin
      chk("feed_timeout", 0, 1);
      return;
    end
    cand = c;
    cand_vld = 1'b1;
    model_cand(c);
    step(1);
    cand_vld = 1'b0;
  endtask

  task automatic wait_vld();
    int n = 0;
    while (!draw_vld && n < 50) begin step(1); n++; end
    if (!draw_vld) chk("vld_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin step(1); n++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int d0;
  initial begin
    model_reset();
    // Reset values
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_vld", draw_vld, 0);
    chk("rst_req", cand_req, 0);
    chk("rst_done", done, 0);
    chk("rst_num", draw_num, 0);
    chk("rst_idx", draw_idx, 0);
    chk("rst_rej", reject_cnt, 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Basic session
    draw_rdy = 1'b1;
    d0 = done_cnt;
    start_session(1'b0);
    feed(8'd5); feed(8'd5); feed(8'd80); feed(8'd0); feed(8'd7); feed(8'd9);
    wait_idle();
    step(1);
    chk("s1_draws", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("s1_d0", got_q[0], 5);
      chk("s1_d1", got_q[1], 7);
      chk("s1_d2", got_q[2], 9);
    end
    chk("s1_rej", reject_cnt, 3);
    chk("s1_idx", draw_idx, 2);
    chk("s1_done", done_cnt - d0, 1);
    chk("s1_busy", busy, 0);

    // Backpressure, with stray cand_vld while in OUTPUT
    draw_rdy = 1'b0;
    start_session(1'b0);
    feed(8'd11);
    wait_vld();
    cand = 8'd50;
    cand_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", draw_vld, 1);
      chk("bp_num", draw_num, 11);
      chk("bp_idx", draw_idx, 0);
      chk("bp_req", cand_req, 0);
      step(1);
    end
    cand_vld = 1'b0;
    draw_rdy = 1'b1;
    d0 = done_cnt;
    feed(8'd12); feed(8'd13);
    wait_idle();
    step(1);
    chk("bp_done", done_cnt - d0, 1);

    // Abort in OUTPUT
    draw_rdy = 1'b0;
    d0 = done_cnt;
    start_session(1'b0);
    feed(8'd5);
    wait_vld();
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("ab_vld", draw_vld, 0);
    chk("ab_busy", busy, 0);
    chk("ab_req", cand_req, 0);
    model_reset();
    step(3);
    chk("ab_no_done", done_cnt - d0, 0);
    // Abort and start edge together in IDLE
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    step(2);
    chk("ab_start_busy", busy, 0);
    draw_rdy = 1'b1;
    start_session(1'b0);
    feed(8'd5); feed(8'd6); feed(8'd7);
    wait_idle();
    step(1);
    chk("ab2_first", (got_q.size() > 0) ? int'(got_q[0]) : -1, 5);
    chk("ab2_done", done_cnt - d0, 1);

    // Start edge in FETCH ignored; held start does not retrigger
    d0 = done_cnt;
    start_session(1'b0);
    begin
      int n = 0;
      while (!cand_req && n < 20) begin step(1); n++; end
    end
    chk("st_fetch", cand_req, 1);
    start = 1'b1;
    step(3);
    chk("st_req", cand_req, 1);
    chk("st_busy", busy, 1);
    feed(8'd21); feed(8'd22); feed(8'd23);
    wait_idle();
    step(5);
    chk("st_hold_busy", busy, 0);
    chk("st_hold_req", cand_req, 0);
    chk("st_one_done", done_cnt - d0, 1);
    start = 1'b0;
    step(1);
    start_session(1'b1);
    chk("st_new_busy", busy, 1);
    feed(8'd24); feed(8'd25); feed(8'd26);
    wait_idle();
    start = 1'b0;
    step(1);
    chk("st_two_done", done_cnt - d0, 2);

    // Reject counter saturation
    start_session(1'b0);
    feed(8'd1);
    for (int i = 0; i < 300; i++) feed(8'd1);
    step(2);
    chk("sat_rej", reject_cnt, 255);
    chk("sat_fetch", cand_req, 1);
    feed(8'd2);
    wait_vld();
    chk("sat_accept", draw_num, 2);
    feed(8'd3);
    wait_idle();

    // Asynchronous reset mid-OUTPUT
    draw_rdy = 1'b0;
    d0 = done_cnt;
    start_session(1'b0);
    feed(8'd20);
    wait_vld();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", draw_vld, 0);
    chk("arst_num", draw_num, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req", cand_req, 0);
    chk("arst_idx", draw_idx, 0);
    chk("arst_rej", reject_cnt, 0);
    chk("arst_done", done, 0);
    model_reset();
    step(2);
    rst_n = 1'b1;
    draw_rdy = 1'b1;
    step(5);
    chk("arst_no_resume", busy, 0);
    chk("arst_no_req", cand_req, 0);
    chk("arst_no_done", done_cnt - d0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
